// File: rtl/prog_loader.sv
// Boot loader: streams a length-prefixed, little-endian word image into mproc memory while holding mproc in reset.
// Writes land one cycle after each word's high byte (>=3 cycles/word); byte_ready drops in WRITE/RUN/ERR to stall the source.
module prog_loader #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              reload,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DAT_LO, DAT_HI, WRITE, RUN, ERR
  } state_t;

  localparam logic [15:0] MAX_LEN = 16'(DEPTH);

  state_t              state, state_nxt;
  logic [15:0]         len, len_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   word, word_nxt;

  logic                xfer;
  logic [15:0]         hdr;
  logic                last_word;

  assign xfer      = byte_valid & byte_ready;
  assign hdr       = {byte_data, len[7:0]};
  assign last_word = (16'(cnt) == len - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LEN_LO;
      len   <= '0;
      cnt   <= '0;
      word  <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
      cnt   <= cnt_nxt;
      word  <= word_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    len_nxt    = len;
    cnt_nxt    = cnt;
    word_nxt   = word;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = cnt;
    mem_wdata  = '0;
    cpu_reset  = 1'b1;
    done       = 1'b0;
    err        = 1'b0;

    case (state)
      LEN_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          len_nxt   = {len[15:8], byte_data};
          state_nxt = LEN_HI;
        end
      end
      LEN_HI: begin
        byte_ready = 1'b1;
        if (xfer) begin
          if (hdr == 16'd0 || hdr > MAX_LEN) begin
            state_nxt = ERR;
          end else begin
            len_nxt   = hdr;
            cnt_nxt   = '0;
            state_nxt = DAT_LO;
          end
        end
      end
      DAT_LO: begin
        byte_ready = 1'b1;
        if (xfer) begin
          word_nxt  = {word[DATA_W-1:8], byte_data};
          state_nxt = DAT_HI;
        end
      end
      DAT_HI: begin
        byte_ready = 1'b1;
        if (xfer) begin
          word_nxt  = {byte_data, word[7:0]};
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wdata = word;
        // cnt stops at len-1, so it never exceeds DEPTH-1 and cannot wrap
        if (last_word) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          state_nxt = DAT_LO;
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        mem_addr  = cpu_addr;
        if (reload) begin
          len_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = LEN_LO;
        end
      end
      ERR: begin
        err = 1'b1;
        if (reload) begin
          len_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = LEN_LO;
        end
      end
      default: state_nxt = LEN_LO;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: header/error handling, gapped streams, async abort and reload.
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        reload;
  logic [6:0]  cpu_addr;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        cpu_reset;
  logic        done;
  logic        err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int we_count = 0;
  logic [6:0]  last_addr = '0;
  logic [15:0] last_data = '0;
  logic [15:0] mem_model [128];

  prog_loader dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .reload(reload), .cpu_addr(cpu_addr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      we_count++;
      mem_model[mem_addr] = mem_wdata;
      last_addr = mem_addr;
      last_data = mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("ready_timeout", 32'(byte_ready), 32'd1);
    step();
    byte_valid = 1'b0;
  endtask

  task automatic idle_junk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      byte_valid = 1'b0;
      byte_data  = 8'hFF;
      reload     = 1'b1;
      step();
    end
    reload = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  initial begin
    int base;
    int mism;
    reset = 1'b0; byte_valid = 1'b0; byte_data = '0; reload = 1'b0; cpu_addr = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done",      32'(done),      32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_we",        32'(mem_we),    32'd0);
    check("rst_wdata",     32'(mem_wdata), 32'd0);
    check("rst_addr",      32'(mem_addr),  32'd0);
    step(); step();
    reset = 1'b0;
    check("rst_ready", 32'(byte_ready), 32'd1);

    // two-word load, continuous stream
    send(8'h02); send(8'h00); send(8'h34); send(8'h12);
    check("w0_we",   32'(mem_we),    32'd1);
    check("w0_addr", 32'(mem_addr),  32'd0);
    check("w0_data", 32'(mem_wdata), 32'h1234);
    check("w0_ready", 32'(byte_ready), 32'd0);
    send(8'hCD); send(8'hAB);
    check("w1_we",   32'(mem_we),    32'd1);
    check("w1_addr", 32'(mem_addr),  32'd1);
    check("w1_data", 32'(mem_wdata), 32'hABCD);
    step();
    cpu_addr = 7'h05;
    #1;
    check("run_done",  32'(done),      32'd1);
    check("run_cpurst", 32'(cpu_reset), 32'd0);
    check("run_addr",  32'(mem_addr),  32'h05);
    check("run_wdata", 32'(mem_wdata), 32'd0);
    check("run_we_cnt", 32'(we_count), 32'd2);

    // zero-length header -> sticky ERR
    pulse_reload();
    check("rl_cpurst", 32'(cpu_reset), 32'd1);
    check("rl_done",   32'(done),      32'd0);
    base = we_count;
    send(8'h00); send(8'h00);
    step(); step(); step();
    check("e0_err",    32'(err),        32'd1);
    check("e0_ready",  32'(byte_ready), 32'd0);
    check("e0_cpurst", 32'(cpu_reset),  32'd1);
    check("e0_nowe",   32'(we_count),   32'(base));
    pulse_reload();
    check("e0_clr_err",   32'(err),        32'd0);
    check("e0_clr_ready", 32'(byte_ready), 32'd1);

    // 129 rejected, 128 accepted
    send(8'h81); send(8'h00);
    check("e129_err", 32'(err), 32'd1);
    pulse_reload();
    base = we_count;
    send(8'h80); send(8'h00);
    check("h128_noerr", 32'(err), 32'd0);
    for (int i = 0; i < 128; i++) begin
      send(8'(i));
      send(8'(i) ^ 8'hA5);
    end
    step();
    mism = 0;
    for (int i = 0; i < 128; i++)
      if (mem_model[i] !== {8'(i) ^ 8'hA5, 8'(i)}) mism++;
    check("big_writes", 32'(we_count - base), 32'd128);
    check("big_last_addr", 32'(last_addr), 32'h7F);
    check("big_last_data", 32'(last_data), 32'hDA7F);
    check("big_mismatch", 32'(mism), 32'd0);
    check("big_done", 32'(done), 32'd1);

    // gapped stream with junk data and ignored reload while stalled
    pulse_reload();
    base = we_count;
    send(8'h01); idle_junk(2);
    send(8'h00); idle_junk(2);
    send(8'h55); idle_junk(2);
    send(8'hAA);
    check("gap_we",   32'(mem_we),    32'd1);
    check("gap_addr", 32'(mem_addr),  32'd0);
    check("gap_data", 32'(mem_wdata), 32'hAA55);
    step();
    check("gap_done", 32'(done), 32'd1);
    check("gap_writes", 32'(we_count - base), 32'd1);

    // async reset during DAT_HI of word 3
    cpu_addr = 7'h33;
    pulse_reload();
    send(8'h05); send(8'h00);
    send(8'h01); send(8'h00);
    send(8'h02); send(8'h00);
    send(8'h03);
    check("ab_addr_pre", 32'(mem_addr), 32'd2);
    #3 reset = 1'b1;
    #1;
    check("ab_addr",   32'(mem_addr),   32'd0);
    check("ab_cpurst", 32'(cpu_reset),  32'd1);
    check("ab_done",   32'(done),       32'd0);
    check("ab_we",     32'(mem_we),     32'd0);
    check("ab_ready",  32'(byte_ready), 32'd1);
    step();
    reset = 1'b0;
    send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
    check("ab_w_addr", 32'(mem_addr),  32'd0);
    check("ab_w_data", 32'(mem_wdata), 32'hBEEF);
    step();
    check("ab_done2", 32'(done), 32'd1);

    // reload from RUN and reload a 1-word image
    pulse_reload();
    check("rr_cpurst", 32'(cpu_reset), 32'd1);
    check("rr_done",   32'(done),      32'd0);
    send(8'h01); send(8'h00); send(8'h11); send(8'h22);
    check("rr_w_data", 32'(mem_wdata), 32'h2211);
    step();
    check("rr_done2",  32'(done),      32'd1);
    check("rr_cpurst2", 32'(cpu_reset), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
